// File: rtl/sna_pkg.sv
// Shared SNA request-path definitions: defaults, packet lengths, FSM encoding
// and the header command-bit position used by the VC buffers and the transmitter.
package sna_pkg;

    localparam int NUM_VC_DEF = 8;
    localparam int FLIT_W_DEF = 32;

    localparam int WR_FLITS = 3;
    localparam int RD_FLITS = 2;

    // Bit of the header flit carrying the command (1 = write, 0 = read)
    localparam int HDR_CMD_BIT = FLIT_W_DEF - 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    function automatic logic [1:0] flit_target(input logic is_write);
        return is_write ? 2'(WR_FLITS) : 2'(RD_FLITS);
    endfunction

endpackage

// File: rtl/sna_vc_arbiter_if.sv
// Flit stream from the VC arbiter to the SNA request transmitter.
// master = arbiter (drives the flit), slave = transmitter (drives tx_ready).
interface sna_vc_arbiter_if
    import sna_pkg::*;
#(
    parameter int NUM_VC = NUM_VC_DEF,
    parameter int FLIT_W = FLIT_W_DEF
);
    localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    logic              tx_valid;
    logic              tx_ready;
    logic [FLIT_W-1:0] tx_flit;
    logic              tx_head;
    logic              tx_last;
    logic [VC_W-1:0]   tx_vc;

    modport master (
        output tx_valid,
        output tx_flit,
        output tx_head,
        output tx_last,
        output tx_vc,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_flit,
        input  tx_head,
        input  tx_last,
        input  tx_vc,
        output tx_ready
    );

endinterface

// File: rtl/sna_rr_arbiter.sv
// Combinational round-robin picker: search starts at ptr+1, wraps modulo NUM_VC,
// and the first requesting VC wins.
module sna_rr_arbiter #(
    parameter int  NUM_VC = 8,
    localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic [NUM_VC-1:0] req,
    input  logic [VC_W-1:0]   ptr,
    output logic [NUM_VC-1:0] gnt,
    output logic [VC_W-1:0]   idx,
    output logic              any_gnt
);

    logic [VC_W-1:0] pos;

    // NOTE: every output gets a default before the loop so no latch can be inferred.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        any_gnt = 1'b0;
        pos     = '0;
        // Scan farthest-first so the nearest requester after ptr is the final write.
        for (int k = NUM_VC; k >= 1; k--) begin
            pos = VC_W'((int'(ptr) + k) % NUM_VC);
            if (req[pos]) begin
                gnt      = '0;
                gnt[pos] = 1'b1;
                idx      = pos;
                any_gnt  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sna_vc_arbiter.sv
// Packet-level round-robin VC arbiter for the SNA request path: holds the grant
// for a whole packet and caps transactions in flight at MAX_OUTST.
module sna_vc_arbiter
    import sna_pkg::*;
#(
    parameter int  NUM_VC    = NUM_VC_DEF,
    parameter int  FLIT_W    = FLIT_W_DEF,
    parameter int  MAX_OUTST = 4,
    localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNT_W     = $clog2(MAX_OUTST) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_VC-1:0]        vc_valid,
    input  logic [NUM_VC-1:0]        vc_head,
    input  logic [NUM_VC-1:0]        vc_write,
    input  logic [NUM_VC*FLIT_W-1:0] vc_flit,
    output logic [NUM_VC-1:0]        vc_pop,
    sna_vc_arbiter_if.master         tx,
    input  logic                     rsp_done,
    output logic [CNT_W-1:0]         outst_cnt,
    output logic                     busy,
    output logic                     err_underflow
);

    logic [0:0]        state;
    logic [VC_W-1:0]   grant;
    logic [NUM_VC-1:0] grant_oh;
    logic [VC_W-1:0]   rr_ptr;
    logic [1:0]        flit_cnt;
    logic [1:0]        flit_tgt;

    logic [NUM_VC-1:0] eligible;
    logic [NUM_VC-1:0] pick_oh;
    logic [VC_W-1:0]   pick_idx;
    logic              pick_any;
    logic              arb_open;
    logic              xfer;
    logic              last_xfer;
    logic [FLIT_W-1:0] flit_arr [NUM_VC];

    for (genvar i = 0; i < NUM_VC; i++) begin : g_flit
        assign flit_arr[i] = vc_flit[i*FLIT_W +: FLIT_W];
    end

    // Only a buffer presenting a header may start a packet.
    assign eligible = vc_valid & vc_head;

    sna_rr_arbiter #(.NUM_VC(NUM_VC)) u_rr (
        .req     (eligible),
        .ptr     (rr_ptr),
        .gnt     (pick_oh),
        .idx     (pick_idx),
        .any_gnt (pick_any)
    );

    assign busy     = (state == ST_BUSY);
    assign arb_open = (state == ST_IDLE) && (outst_cnt < CNT_W'(MAX_OUTST));

    assign tx.tx_valid = busy & vc_valid[grant];
    assign tx.tx_flit  = busy ? flit_arr[grant] : '0;
    assign tx.tx_head  = busy && (flit_cnt == 2'd0);
    assign tx.tx_last  = busy && (flit_cnt == flit_tgt - 2'd1);
    assign tx.tx_vc    = grant;

    assign xfer      = tx.tx_valid & tx.tx_ready;
    assign last_xfer = xfer & tx.tx_last;
    assign vc_pop    = xfer ? grant_oh : '0;

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            grant_oh <= '0;
            rr_ptr   <= VC_W'(NUM_VC - 1);
            flit_cnt <= '0;
            flit_tgt <= '0;
        end else if (state == ST_IDLE) begin
            if (arb_open && pick_any) begin
                grant    <= pick_idx;
                grant_oh <= pick_oh;
                flit_tgt <= flit_target(vc_write[pick_idx]);
                flit_cnt <= '0;
                state    <= ST_BUSY;
            end
        end else if (xfer) begin
            flit_cnt <= flit_cnt + 2'd1;
            if (tx.tx_last) begin
                rr_ptr <= grant;
                state  <= ST_IDLE;
            end
        end
    end

    // A completion and a new last flit in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            outst_cnt     <= '0;
            err_underflow <= 1'b0;
        end else if (last_xfer && !rsp_done) begin
            outst_cnt <= outst_cnt + CNT_W'(1);
        end else if (rsp_done && !last_xfer) begin
            if (outst_cnt == '0) begin
                err_underflow <= 1'b1;
            end else begin
                outst_cnt <= outst_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sna_vc_arbiter.sv
// Bench for sna_vc_arbiter: grant table, directed multi-cycle sequences and
// random traffic checked against a packet-level reference model.
module tb_sna_vc_arbiter;

    localparam int N     = 8;
    localparam int W     = 32;
    localparam int MO    = 4;
    localparam int DEPTH = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   vc_valid, vc_head, vc_write, vc_pop;
    logic [N*W-1:0] vc_flit;
    logic           rsp_done;
    logic [2:0]     outst_cnt;
    logic           busy, err_underflow;

    sna_vc_arbiter_if #(.NUM_VC(N), .FLIT_W(W)) tx_if ();

    sna_vc_arbiter #(.NUM_VC(N), .FLIT_W(W), .MAX_OUTST(MO)) dut (
        .clk           (clk),
        .rst           (rst),
        .vc_valid      (vc_valid),
        .vc_head       (vc_head),
        .vc_write      (vc_write),
        .vc_flit       (vc_flit),
        .vc_pop        (vc_pop),
        .tx            (tx_if),
        .rsp_done      (rsp_done),
        .outst_cnt     (outst_cnt),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // VC buffers: circular stores of whole packets
    typedef struct packed {
        logic [W-1:0] data;
        logic         head;
        logic         wr;
    } flit_t;

    flit_t mem [N][DEPTH];
    int    rd_p [N];
    int    wr_p [N];

    function automatic int occ(input int v);
        return wr_p[v] - rd_p[v];
    endfunction

    task automatic push_pkt(input int v, input bit wr, input logic [W-1:0] base);
        flit_t f;
        for (int k = 0; k < (wr ? 3 : 2); k++) begin
            f.data = base + W'(k);
            f.head = (k == 0);
            f.wr   = (k == 0) ? wr : 1'($urandom);
            mem[v][wr_p[v] % DEPTH] = f;
            wr_p[v]++;
        end
    endtask

    // Reference model: which VC owns the output, how far into its packet, etc.
    int m_lock, m_idx, m_tgt, m_ptr, m_outst;
    bit m_err;

    // Observations taken from the DUT outputs
    int           cyc;
    int           hdr_vc[$];
    int           hdr_cyc[$];
    logic [W-1:0] xf_data[$];
    int           xf_head[$];
    int           xf_last[$];
    int           pops [N];

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic env_clear();
        m_lock = -1; m_idx = 0; m_tgt = 0; m_ptr = N - 1; m_outst = 0; m_err = 0;
        cyc = 0;
        hdr_vc.delete(); hdr_cyc.delete();
        xf_data.delete(); xf_head.delete(); xf_last.delete();
        for (int i = 0; i < N; i++) begin
            rd_p[i] = 0; wr_p[i] = 0; pops[i] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rsp_done = 1'b0; tx_if.tx_ready = 1'b0;
        vc_valid = '0; vc_head = '0; vc_write = '0; vc_flit = '0;
        tick();
        tick();
        rst = 1'b0;
        env_clear();
    endtask

    // One clock cycle: present buffer heads, compare DUT to model, advance both.
    task automatic step(input bit ready, input bit rsp, input logic [N-1:0] hold);
        logic [N-1:0] v, h, wb, exp_pop;
        logic [W-1:0] fd [N];
        logic [W-1:0] exp_flit;
        flit_t        f;
        bit           bz, ev, eh, el, xfer;
        for (int i = 0; i < N; i++) begin
            if (occ(i) > 0) begin
                f = mem[i][rd_p[i] % DEPTH];
                v[i] = !hold[i]; h[i] = f.head; wb[i] = f.wr; fd[i] = f.data;
            end else begin
                v[i] = 1'b0; h[i] = 1'b0; wb[i] = 1'($urandom); fd[i] = '0;
            end
        end
        vc_valid = v; vc_head = h; vc_write = wb;
        for (int i = 0; i < N; i++) vc_flit[i*W +: W] = fd[i];
        tx_if.tx_ready = ready;
        rsp_done = rsp;
        #1;
        bz       = (m_lock >= 0);
        ev       = bz ? v[m_lock] : 1'b0;
        exp_flit = bz ? fd[m_lock] : '0;
        eh       = bz && (m_idx == 0);
        el       = bz && (m_idx == m_tgt - 1);
        xfer     = ev && ready;
        exp_pop  = '0;
        if (xfer) exp_pop[m_lock] = 1'b1;
        check("busy", busy, bz);
        check("tx_valid", tx_if.tx_valid, ev);
        check("tx_head", tx_if.tx_head, eh);
        check("tx_last", tx_if.tx_last, el);
        check("tx_flit", tx_if.tx_flit, exp_flit);
        check("vc_pop", vc_pop, exp_pop);
        check("outst_cnt", outst_cnt, m_outst);
        check("err_underflow", err_underflow, m_err);
        if (bz) check("tx_vc", tx_if.tx_vc, m_lock);
        if (tx_if.tx_valid && tx_if.tx_ready) begin
            xf_data.push_back(tx_if.tx_flit);
            xf_head.push_back(int'(tx_if.tx_head));
            xf_last.push_back(int'(tx_if.tx_last));
            if (tx_if.tx_head) begin
                hdr_vc.push_back(int'(tx_if.tx_vc));
                hdr_cyc.push_back(cyc);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (vc_pop[i]) begin
                pops[i]++;
                if (occ(i) > 0) rd_p[i]++;
            end
        end
        if (!bz) begin
            if (m_outst < MO) begin
                for (int k = 1; k <= N; k++) begin
                    if (v[(m_ptr + k) % N] && h[(m_ptr + k) % N]) begin
                        m_lock = (m_ptr + k) % N;
                        m_tgt  = wb[m_lock] ? 3 : 2;
                        m_idx  = 0;
                        break;
                    end
                end
            end
        end else if (xfer) begin
            if (el) begin
                m_ptr  = m_lock;
                m_lock = -1;
            end else begin
                m_idx++;
            end
        end
        if (xfer && el && !rsp) m_outst++;
        else if (rsp && !(xfer && el)) begin
            if (m_outst == 0) m_err = 1;
            else m_outst--;
        end
        cyc++;
        tick();
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] head;
        logic [N-1:0] wr;
        bit           exp_busy;
        int           exp_vc;
        bit           exp_last;
    } vec_t;

    vec_t vecs [8];

    int a_data [3] = '{32'hA, 32'hB, 32'hC};
    int a_head [3] = '{1, 0, 0};
    int a_last [3] = '{0, 0, 1};
    int r;

    initial begin
        vecs[0] = '{8'h08, 8'h08, 8'h08, 1'b1, 3, 1'b0};
        vecs[1] = '{8'h25, 8'h25, 8'h24, 1'b1, 0, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 0, 1'b0};
        vecs[3] = '{8'hF0, 8'hA0, 8'h20, 1'b1, 5, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1, 7, 1'b1};
        vecs[5] = '{8'h00, 8'hFF, 8'hFF, 1'b0, 0, 1'b0};
        vecs[6] = '{8'h06, 8'h04, 8'h00, 1'b1, 2, 1'b1};
        vecs[7] = '{8'h83, 8'h82, 8'h02, 1'b1, 1, 1'b0};

        // Grant table: reset state, first pick from pointer NUM_VC-1, target latch
        for (int t = 0; t < 8; t++) begin
            do_reset();
            vc_valid = vecs[t].valid; vc_head = vecs[t].head; vc_write = vecs[t].wr;
            for (int i = 0; i < N; i++) vc_flit[i*W +: W] = 32'h1000_0000 + W'(i);
            #1;
            check("rst busy", busy, 0);
            check("rst tx_valid", tx_if.tx_valid, 0);
            check("rst tx_head", tx_if.tx_head, 0);
            check("rst tx_last", tx_if.tx_last, 0);
            check("rst tx_vc", tx_if.tx_vc, 0);
            check("rst tx_flit", tx_if.tx_flit, 0);
            check("rst vc_pop", vc_pop, 0);
            check("rst outst_cnt", outst_cnt, 0);
            check("rst err", err_underflow, 0);
            tick();
            check("tbl busy", busy, vecs[t].exp_busy);
            check("tbl tx_head", tx_if.tx_head, vecs[t].exp_busy);
            check("tbl tx_valid", tx_if.tx_valid, vecs[t].exp_busy);
            check("tbl tx_flit", tx_if.tx_flit,
                  vecs[t].exp_busy ? 32'h1000_0000 + W'(vecs[t].exp_vc) : 32'h0);
            if (vecs[t].exp_busy) check("tbl tx_vc", tx_if.tx_vc, vecs[t].exp_vc);
            tx_if.tx_ready = 1'b1;
            #1;
            check("tbl vc_pop", vc_pop, vecs[t].exp_busy ? (64'h1 << vecs[t].exp_vc) : 64'h0);
            tick();
            check("tbl tx_last", tx_if.tx_last, vecs[t].exp_last);
        end

        // Write packet on VC3
        do_reset();
        push_pkt(3, 1'b1, 32'hA);
        repeat (6) step(1'b1, 1'b0, '0);
        check("A hdr count", hdr_vc.size(), 1);
        check("A hdr vc", q_at(hdr_vc, 0), 3);
        check("A hdr cycle", q_at(hdr_cyc, 0), 1);
        check("A pops vc3", pops[3], 3);
        check("A flit count", xf_data.size(), 3);
        for (int k = 0; k < 3 && k < xf_data.size(); k++) begin
            check("A flit data", xf_data[k], a_data[k]);
            check("A flit head", xf_head[k], a_head[k]);
            check("A flit last", xf_last[k], a_last[k]);
        end
        check("A outst", outst_cnt, 1);

        // Round-robin order 0,2,5,0 with one idle cycle between packets
        do_reset();
        push_pkt(0, 1'b0, 32'h100);
        push_pkt(2, 1'b0, 32'h200);
        push_pkt(5, 1'b0, 32'h500);
        push_pkt(0, 1'b0, 32'h110);
        repeat (14) step(1'b1, 1'b0, '0);
        check("B order 0", q_at(hdr_vc, 0), 0);
        check("B order 1", q_at(hdr_vc, 1), 2);
        check("B order 2", q_at(hdr_vc, 2), 5);
        check("B order 3", q_at(hdr_vc, 3), 0);
        check("B cyc 1", q_at(hdr_cyc, 1), 4);
        check("B cyc 2", q_at(hdr_cyc, 2), 7);
        check("B cyc 3", q_at(hdr_cyc, 3), 10);
        check("B outst", outst_cnt, 4);

        // Outstanding limit reached, then one rsp_done frees a slot
        push_pkt(6, 1'b0, 32'h600);
        repeat (5) step(1'b1, 1'b0, '0);
        check("C blocked hdrs", hdr_vc.size(), 4);
        check("C blocked busy", busy, 0);
        r = cyc;
        step(1'b1, 1'b1, '0);
        repeat (4) step(1'b1, 1'b0, '0);
        check("C hdr vc", q_at(hdr_vc, 4), 6);
        check("C hdr cycle", q_at(hdr_cyc, 4), r + 2);
        check("C outst", outst_cnt, 4);

        // Mid-packet stall on the granted VC
        do_reset();
        push_pkt(1, 1'b1, 32'h1000);
        push_pkt(4, 1'b0, 32'h4000);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        repeat (3) begin
            step(1'b1, 1'b0, 8'h02);
            check("D stall busy", busy, 1);
            check("D stall vc", tx_if.tx_vc, 1);
            check("D stall no vc4 pop", pops[4], 0);
            check("D stall vc1 pops", pops[1], 1);
        end
        repeat (8) step(1'b1, 1'b0, '0);
        check("D pops vc1", pops[1], 3);
        check("D pops vc4", pops[4], 2);
        check("D order", q_at(hdr_vc, 1), 4);
        check("D vc4 hdr cycle", q_at(hdr_cyc, 1), 8);

        // rsp_done coincident with last flit, then underflow
        do_reset();
        push_pkt(2, 1'b0, 32'h20);
        push_pkt(3, 1'b0, 32'h30);
        repeat (5) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, '0);
        check("E coincident outst", outst_cnt, 1);
        check("E coincident err", err_underflow, 0);
        step(1'b1, 1'b1, '0);
        check("E drain outst", outst_cnt, 0);
        step(1'b1, 1'b1, '0);
        step(1'b1, 1'b0, '0);
        check("E underflow outst", outst_cnt, 0);
        check("E underflow err", err_underflow, 1);

        // Reset during flit 2 of a write
        do_reset();
        push_pkt(0, 1'b0, 32'h50);
        repeat (4) step(1'b1, 1'b0, '0);
        push_pkt(6, 1'b1, 32'h60);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        check("F pre outst", outst_cnt, 1);
        check("F pre busy", busy, 1);
        rst = 1'b1; tx_if.tx_ready = 1'b0;
        tick();
        rst = 1'b0; tx_if.tx_ready = 1'b1;
        vc_valid = '0; vc_head = '0; vc_write = '0; vc_flit = '0;
        #1;
        check("F busy", busy, 0);
        check("F outst", outst_cnt, 0);
        check("F vc_pop", vc_pop, 0);
        check("F tx_valid", tx_if.tx_valid, 0);
        check("F tx_head", tx_if.tx_head, 0);
        env_clear();
        push_pkt(1, 1'b0, 32'h71);
        push_pkt(0, 1'b0, 32'h70);
        repeat (4) step(1'b1, 1'b0, '0);
        check("F ptr reset pick", q_at(hdr_vc, 0), 0);

        // Random traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] hold;
            int           v;
            if ($urandom_range(0, 7) == 0) begin
                v = $urandom_range(0, N - 1);
                if (occ(v) < DEPTH - 4) push_pkt(v, 1'($urandom), {8'(v), 16'(c), 8'h00});
            end
            for (int i = 0; i < N; i++) hold[i] = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, hold);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
